// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: BCD input and scan output bundle between datapath, scanner and segment decoder
interface disp_scan_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int BRIGHT_W = 4
);
  logic enable;
  logic [3:0] number [DIGITS];
  logic [DIGITS-1:0] dp_in;
  logic lz_suppress;
  logic [BRIGHT_W-1:0] brightness;
  logic [3:0] output_number;
  logic dp_out;
  logic blank;
  logic [DIGITS-1:0] digit_select;
  logic frame_tick;
  modport master (
    output enable, number, dp_in, lz_suppress, brightness,
    input output_number, dp_out, blank, digit_select, frame_tick
  );
  modport slave (
    input enable, number, dp_in, lz_suppress, brightness,
    output output_number, dp_out, blank, digit_select, frame_tick
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: multiplexed common-anode 7-segment scanner with dead-time, PWM dimming and leading-zero blanking
module disp_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int REFRESH_CYCLES = 2**19,
  parameter int BLANK_CYCLES = 1024,
  parameter int BRIGHT_W = 4
) (
  input logic clk,
  input logic reset,
  disp_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam int IW = $clog2(DIGITS);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic [BRIGHT_W-1:0] pwm_q, bright_q;
  logic [3:0] num_q [DIGITS];
  logic [DIGITS-1:0] dp_q, sup, sel_q;
  logic lz_q, allz, drv, slot_end, wrap, latch;
  logic [3:0] onum_q;
  logic dpo_q, blank_q, tick_q;
  assign slot_end = state_q == DRIVE && cnt_q == SLOT_LAST;
  assign wrap = slot_end && idx_q == IDX_LAST;
  assign latch = bus.enable && (state_q == OFF || wrap);
  assign drv = bus.enable && state_q == DRIVE && !sup[idx_q] && (pwm_q < bright_q || &bright_q);
  assign bus.digit_select = sel_q;
  assign bus.output_number = onum_q;
  assign bus.dp_out = dpo_q;
  assign bus.blank = blank_q;
  assign bus.frame_tick = tick_q;
  // a digit is suppressed when it and every more significant shadow digit are zero; digit 0 always shows
  always_comb begin
    sup = '0;
    allz = lz_q;
    for (int i = DIGITS - 1; i > 0; i--) begin
      allz = allz && num_q[i] == 4'd0;
      sup[i] = allz;
    end
  end
  // scan FSM, frame shadow latch and registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= OFF;
      cnt_q <= '0;
      idx_q <= '0;
      pwm_q <= '0;
      bright_q <= '0;
      num_q <= '{default: '0};
      dp_q <= '0;
      lz_q <= 1'b0;
      sel_q <= '1;
      onum_q <= 4'd0;
      dpo_q <= 1'b0;
      blank_q <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      sel_q <= drv ? ~(DIGITS'(1) << idx_q) : '1;
      onum_q <= drv ? num_q[idx_q] : 4'd0;
      dpo_q <= drv && dp_q[idx_q];
      blank_q <= !drv;
      tick_q <= latch;
      if (latch) begin
        num_q <= bus.number;
        dp_q <= bus.dp_in;
        lz_q <= bus.lz_suppress;
        bright_q <= bus.brightness;
      end
      if (!bus.enable) begin
        state_q <= OFF;
        cnt_q <= '0;
        idx_q <= '0;
        pwm_q <= '0;
      end else begin
        case (state_q)
          OFF: state_q <= BLANK;
          BLANK: begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == BLANK_LAST) begin
              state_q <= DRIVE;
              pwm_q <= '0;
            end
          end
          DRIVE: begin
            pwm_q <= pwm_q + BRIGHT_W'(1);
            cnt_q <= slot_end ? '0 : cnt_q + CW'(1);
            if (slot_end) begin
              state_q <= BLANK;
              idx_q <= wrap ? '0 : idx_q + IW'(1);
            end
          end
          default: state_q <= OFF;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed vector bench for the display scanner
module tb_disp_scan_ctrl;
  logic clk, reset;
  int k, n_chk, n_fail;
  disp_scan_ctrl_if #(.DIGITS(4), .BRIGHT_W(2)) bus ();
  disp_scan_ctrl #(.DIGITS(4), .REFRESH_CYCLES(16), .BLANK_CYCLES(2), .BRIGHT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  typedef struct {
    bit rs;
    logic [15:0] num;
    logic [3:0] dp;
    logic lz;
    logic [1:0] br;
    int k;
    logic [3:0] sel;
    logic [3:0] on;
    logic dpo;
    logic blk;
    logic tk;
  } vec_t;
  vec_t vt[$];
  logic [15:0] c_num;
  logic [3:0] c_dp;
  logic c_lz;
  logic [1:0] c_br;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic add(input bit rs, input int kk, input logic [3:0] sel, input logic [3:0] on,
                     input logic dpo, input logic blk, input logic tk);
    vt.push_back('{rs, c_num, c_dp, c_lz, c_br, kk, sel, on, dpo, blk, tk});
  endtask
  task automatic set_num(input logic [15:0] num);
    for (int i = 0; i < 4; i++) bus.number[i] = num[4*i +: 4];
  endtask
  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask
  task automatic restart(input logic [15:0] num, input logic [3:0] dp, input logic lz, input logic [1:0] br);
    @(negedge clk);
    reset = 1'b1;
    bus.enable = 1'b0;
    set_num(num);
    bus.dp_in = dp;
    bus.lz_suppress = lz;
    bus.brightness = br;
    #1 reset = 1'b0;
    bus.enable = 1'b1;
    k = 0;
  endtask
  task automatic chk(input string nm, input logic [3:0] s, input logic [3:0] n, input logic d,
                     input logic b, input logic t);
    n_chk++;
    if (bus.digit_select !== s || bus.output_number !== n || bus.dp_out !== d || bus.blank !== b || bus.frame_tick !== t) begin
      n_fail++;
      $display("FAIL %s: got sel=%b num=%h dp=%b blank=%b tick=%b, want sel=%b num=%h dp=%b blank=%b tick=%b",
               nm, bus.digit_select, bus.output_number, bus.dp_out, bus.blank, bus.frame_tick, s, n, d, b, t);
    end
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    k = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    set_num(16'h0);
    bus.dp_in = 4'h0;
    bus.lz_suppress = 1'b0;
    bus.brightness = 2'd0;
    // basic scan, full brightness
    c_num = 16'h4321; c_dp = 4'h0; c_lz = 1'b0; c_br = 2'd3;
    add(1, 1, 4'hF, 4'h0, 0, 1, 1);
    add(0, 2, 4'hF, 4'h0, 0, 1, 0);
    add(0, 4, 4'hE, 4'h1, 0, 0, 0);
    add(0, 17, 4'hE, 4'h1, 0, 0, 0);
    add(0, 18, 4'hF, 4'h0, 0, 1, 0);
    add(0, 20, 4'hD, 4'h2, 0, 0, 0);
    add(0, 36, 4'hB, 4'h3, 0, 0, 0);
    add(0, 52, 4'h7, 4'h4, 0, 0, 0);
    add(0, 65, 4'h7, 4'h4, 0, 0, 1);
    add(0, 66, 4'hF, 4'h0, 0, 1, 0);
    add(0, 68, 4'hE, 4'h1, 0, 0, 0);
    add(0, 129, 4'h7, 4'h4, 0, 0, 1);
    // leading-zero suppression
    c_num = 16'h0005; c_lz = 1'b1;
    add(1, 4, 4'hE, 4'h5, 0, 0, 0);
    add(0, 20, 4'hF, 4'h0, 0, 1, 0);
    add(0, 36, 4'hF, 4'h0, 0, 1, 0);
    add(0, 52, 4'hF, 4'h0, 0, 1, 0);
    add(0, 65, 4'hF, 4'h0, 0, 1, 1);
    c_num = 16'h0000;
    add(1, 4, 4'hE, 4'h0, 0, 0, 0);
    add(0, 20, 4'hF, 4'h0, 0, 1, 0);
    // brightness 1: driven only on pwm 0
    c_num = 16'h4321; c_lz = 1'b0; c_br = 2'd1;
    add(1, 4, 4'hE, 4'h1, 0, 0, 0);
    add(0, 5, 4'hF, 4'h0, 0, 1, 0);
    add(0, 7, 4'hF, 4'h0, 0, 1, 0);
    add(0, 8, 4'hE, 4'h1, 0, 0, 0);
    add(0, 16, 4'hE, 4'h1, 0, 0, 0);
    add(0, 17, 4'hF, 4'h0, 0, 1, 0);
    // brightness 0: dark but ticking
    c_br = 2'd0;
    add(1, 4, 4'hF, 4'h0, 0, 1, 0);
    add(0, 20, 4'hF, 4'h0, 0, 1, 0);
    add(0, 65, 4'hF, 4'h0, 0, 1, 1);
    // decimal point on digit 2, digit value above 9 passes through
    c_num = 16'h4F21; c_dp = 4'b0100; c_br = 2'd3;
    add(1, 4, 4'hE, 4'h1, 0, 0, 0);
    add(0, 34, 4'hF, 4'h0, 0, 1, 0);
    add(0, 36, 4'hB, 4'hF, 1, 0, 0);
    add(0, 52, 4'h7, 4'h4, 0, 0, 0);
    #2 chk("reset_state", 4'hF, 4'h0, 0, 1, 0);
    foreach (vt[i]) begin
      if (vt[i].rs) restart(vt[i].num, vt[i].dp, vt[i].lz, vt[i].br);
      while (k < vt[i].k) step();
      chk($sformatf("vec%0d_k%0d", i, vt[i].k), vt[i].sel, vt[i].on, vt[i].dpo, vt[i].blk, vt[i].tk);
    end
    // tear-free update: number[2] changes during slot 1
    restart(16'h4321, 4'h0, 1'b0, 2'd3);
    while (k < 20) step();
    set_num(16'h4921);
    while (k < 36) step();
    chk("tear_cur_frame", 4'hB, 4'h3, 0, 0, 0);
    while (k < 100) step();
    chk("tear_next_frame", 4'hB, 4'h9, 0, 0, 0);
    // enable dropped mid slot 2, then re-enabled
    restart(16'h4321, 4'h0, 1'b0, 2'd3);
    while (k < 40) step();
    chk("pre_disable", 4'hB, 4'h3, 0, 0, 0);
    bus.enable = 1'b0;
    step();
    chk("disable_off", 4'hF, 4'h0, 0, 1, 0);
    bus.enable = 1'b1;
    k = 0;
    step();
    chk("reen_tick", 4'hF, 4'h0, 0, 1, 1);
    step();
    chk("reen_blank", 4'hF, 4'h0, 0, 1, 0);
    step();
    step();
    chk("reen_drive0", 4'hE, 4'h1, 0, 0, 0);
    // asynchronous reset mid DRIVE
    #1 reset = 1'b1;
    #1 chk("async_reset", 4'hF, 4'h0, 0, 1, 0);
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Parametrised scan controller for multiplexed common-anode 7-segment displays. It time-multiplexes `DIGITS` BCD values onto one shared segment bus, with per-digit dead-time, PWM brightness control, leading-zero suppression and decimal-point pass-through. Input values are latched once per frame so a digit never shows a torn update. It sits between the calculator datapath (BCD result registers) and the BCD-to-segment decoder driving the board pins.

## Interface
Parameters:
- `DIGITS`, 4: number of digits scanned; ≥2.
- `REFRESH_CYCLES`, 2**19: clock cycles per digit slot; > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 1024: dead-time cycles at the start of each slot, all digits off; ≥1.
- `BRIGHT_W`, 4: brightness code width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: 1 = scanning, 0 = display off.
- `number` in 4×`DIGITS`: BCD per digit (unpacked array `[DIGITS]`); index 0 = least significant/rightmost.
- `dp_in` in `DIGITS`: decimal point request per digit.
- `lz_suppress` in 1: 1 = blank leading zeros.
- `brightness` in `BRIGHT_W`: 0 = dark, all-ones = full on.
- `output_number` out 4: BCD of the currently driven digit; 0 when blanked.
- `dp_out` out 1: decimal point of the driven digit, active-high; 0 when blanked.
- `blank` out 1: 1 = no digit driven this cycle.
- `digit_select` out `DIGITS`: one-cold digit enable; all-ones = none.
- `frame_tick` out 1: one-cycle pulse at each frame start.

## Operation
- Reset values: `digit_select` all ones, `output_number` 0, `dp_out` 0, `blank` 1, `frame_tick` 0. Slot counter, slot index, PWM counter and shadow registers are cleared. The FSM enters OFF.
- FSM states:
  - OFF: outputs at their reset values; counters held at 0.
  - BLANK: slot counter < `BLANK_CYCLES`.
  - DRIVE: remainder of the slot.
- Transitions:
  - OFF→BLANK on `enable`=1, starting slot 0 with a frame latch.
  - BLANK→DRIVE when slot counter reaches `BLANK_CYCLES`.
  - DRIVE→BLANK when slot counter reaches `REFRESH_CYCLES`-1. The slot index then increments; it wraps `DIGITS`-1→0.
  - Any state→OFF on `enable`=0, taking effect on the next clock edge.
- Frame latch: on entry from OFF, and whenever the slot index wraps to 0, the block captures `number`, `dp_in`, `lz_suppress` and `brightness` into shadow registers. `frame_tick` pulses 1 on the wrap cycle. All display decisions use shadow values only.
- Leading-zero suppression (shadow `lz_suppress`=1): digit i>0 is suppressed iff shadow number[j]==0 for all j≥i. Digit 0 is never suppressed. A suppressed digit behaves as blanked (select all ones, `blank`=1, dp forced 0).
- Brightness: the `BRIGHT_W`-bit PWM counter increments every DRIVE cycle and is reset to 0 at each DRIVE entry.
  - Digit is driven iff pwm < shadow brightness, or shadow brightness is all-ones.
  - Brightness 0 gives a fully dark display, but scan and `frame_tick` continue.
- Driven digit i: `digit_select[i]`=0, others 1; `output_number`=shadow number[i]; `dp_out`=shadow dp[i]; `blank`=0.
- Values >9 on `number` pass through unchanged; decoding them is the downstream decoder's job.

## Timing
- All outputs are registered: each reflects the FSM/counter state of the previous cycle (1-cycle latency).
- Slot = `REFRESH_CYCLES` cycles; frame = `DIGITS`×`REFRESH_CYCLES` cycles.
- At most `REFRESH_CYCLES`−`BLANK_CYCLES` cycles are driven per slot.
- `digit_select` never has more than one 0 bit in any cycle.
- At least `BLANK_CYCLES` all-ones cycles occur between two different digits being driven.
- `enable` deasserted mid-slot: next-edge outputs go to OFF values and counters clear. Re-enable restarts at slot 0, BLANK, with a new frame latch.
- Asynchronous `reset` mid-operation: outputs take their reset values immediately, without waiting for a clock edge.
- Input changes mid-frame are not visible until the next frame latch.

## Test plan
Parameters for all scenarios: `DIGITS`=4, `REFRESH_CYCLES`=16, `BLANK_CYCLES`=2, `BRIGHT_W`=2.
- Basic scan: number={1,2,3,4}, brightness=3, enable=1.
  - Each slot shows 2 cycles of select 1111, then 14 cycles of 1110/1101/1011/0111 with output 1/2/3/4.
  - `frame_tick` pulses every 64 cycles.
- Leading-zero suppression: number={5,0,0,0}, lz_suppress=1.
  - Only digit 0 is ever driven, showing 5; slots 1–3 stay all-ones with `blank`=1.
  - With number={0,0,0,0}, digit 0 shows 0.
- Brightness: brightness=1.
  - Each DRIVE phase is driven 1 cycle in every 4 (pwm=0 only).
  - brightness=0 gives select always 1111 while `frame_tick` still pulses.
- Tear-free update: change number[2] from 3 to 9 during slot 1.
  - Slot 2 of the current frame shows 3; slot 2 of the next frame shows 9.
- Enable/reset mid-slot: drop enable at cycle 7 of slot 2.
  - The next cycle shows all OFF values.
  - On re-enable, BLANK in slot 0 is driven two cycles after enable rises.
  - Asynchronous reset asserted mid-DRIVE clears outputs with no clock edge.
- Decimal point: dp_in=4'b0100 shows `dp_out`=1 only while digit 2 is driven, and 0 during blanking.
